// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: load-use interlock, branch squash,
// and I/D cache-line fill sequencing over the shared main-memory port (D-cache first).
module hazard_stall_ctrl #(
  parameter int unsigned FILL_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    IF_ID_SrcReg1,
  input  logic [3:0]                    IF_ID_SrcReg2,
  input  logic                          ID_uses_Src1,
  input  logic                          ID_uses_Src2,
  input  logic                          ID_is_SW,
  input  logic                          ID_EX_MemRead,
  input  logic [3:0]                    ID_EX_reg_rd,
  input  logic                          ID_Branch_taken,
  input  logic                          I_miss,
  input  logic                          D_miss,
  input  logic                          mem_data_valid,
  output logic                          PC_stall,
  output logic                          IF_ID_stall,
  output logic                          IF_ID_flush,
  output logic                          ID_EX_stall,
  output logic                          EX_MEM_stall,
  output logic                          ID_EX_flush,
  output logic                          MEM_WB_flush,
  output logic                          mem_req,
  output logic                          mem_sel_D,
  output logic [$clog2(FILL_WORDS)-1:0] fill_idx,
  output logic                          fill_we,
  output logic                          fill_done,
  output logic [15:0]                   stall_cycles
);

  localparam int unsigned IdxW = $clog2(FILL_WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FILL_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StDFill, StIFill} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   cnt_q, cnt_d;
  logic [15:0]       stall_q, stall_d;
  logic              dfreeze, ifreeze, load_use;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // Counter is held at zero in idle, so each fill starts at word 0; the last beat wraps it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (D_miss) begin
          state_d = StDFill;
        end else if (I_miss) begin
          state_d = StIFill;
        end
      end
      StDFill, StIFill: begin
        if (mem_data_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req   = (state_q != StIdle);
    mem_sel_D = (state_q == StDFill);
    fill_idx  = cnt_q;
    fill_we   = mem_req && mem_data_valid;
    fill_done = fill_we && (cnt_q == LastIdx);
  end

  // SW store data is covered by MEM-to-MEM forwarding, so only its base register interlocks.
  always_comb begin
    dfreeze  = D_miss || (state_q == StDFill);
    ifreeze  = I_miss || (state_q == StIFill);
    load_use = ID_EX_MemRead && (ID_EX_reg_rd != 4'd0) &&
               (((IF_ID_SrcReg1 == ID_EX_reg_rd) && ID_uses_Src1) ||
                ((IF_ID_SrcReg2 == ID_EX_reg_rd) && ID_uses_Src2 && !ID_is_SW));
  end

  always_comb begin
    PC_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_stall  = 1'b0;
    EX_MEM_stall = 1'b0;
    ID_EX_flush  = 1'b0;
    MEM_WB_flush = 1'b0;
    if (dfreeze) begin
      PC_stall     = 1'b1;
      IF_ID_stall  = 1'b1;
      ID_EX_stall  = 1'b1;
      EX_MEM_stall = 1'b1;
      MEM_WB_flush = 1'b1;
    end else if (load_use) begin
      PC_stall    = 1'b1;
      IF_ID_stall = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (ifreeze) begin
      PC_stall    = 1'b1;
      IF_ID_flush = 1'b1;
    end else if (ID_Branch_taken) begin
      IF_ID_flush = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (PC_stall && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomised and directed bench for hazard_stall_ctrl against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

  localparam int FW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] IF_ID_SrcReg1, IF_ID_SrcReg2, ID_EX_reg_rd;
  logic       ID_uses_Src1, ID_uses_Src2, ID_is_SW, ID_EX_MemRead, ID_Branch_taken;
  logic       I_miss, D_miss, mem_data_valid;
  logic       PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, EX_MEM_stall;
  logic       ID_EX_flush, MEM_WB_flush, mem_req, mem_sel_D, fill_we, fill_done;
  logic [2:0] fill_idx;
  logic [15:0] stall_cycles;

  hazard_stall_ctrl #(.FILL_WORDS(FW)) dut (
    .clk             (clk),
    .rst             (rst),
    .IF_ID_SrcReg1   (IF_ID_SrcReg1),
    .IF_ID_SrcReg2   (IF_ID_SrcReg2),
    .ID_uses_Src1    (ID_uses_Src1),
    .ID_uses_Src2    (ID_uses_Src2),
    .ID_is_SW        (ID_is_SW),
    .ID_EX_MemRead   (ID_EX_MemRead),
    .ID_EX_reg_rd    (ID_EX_reg_rd),
    .ID_Branch_taken (ID_Branch_taken),
    .I_miss          (I_miss),
    .D_miss          (D_miss),
    .mem_data_valid  (mem_data_valid),
    .PC_stall        (PC_stall),
    .IF_ID_stall     (IF_ID_stall),
    .IF_ID_flush     (IF_ID_flush),
    .ID_EX_stall     (ID_EX_stall),
    .EX_MEM_stall    (EX_MEM_stall),
    .ID_EX_flush     (ID_EX_flush),
    .MEM_WB_flush    (MEM_WB_flush),
    .mem_req         (mem_req),
    .mem_sel_D       (mem_sel_D),
    .fill_idx        (fill_idx),
    .fill_we         (fill_we),
    .fill_done       (fill_done),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which cache is being filled (0 none, 1 D, 2 I), beats received, stalled cycles.
  int m_fill  = 0;
  int m_beats = 0;
  int m_stall = 0;
  bit e_pc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic set_dec(input bit mr, input int rd, input int s1, input bit u1,
                         input int s2, input bit u2, input bit sw, input bit br);
    ID_EX_MemRead   = mr;
    ID_EX_reg_rd    = 4'(rd);
    IF_ID_SrcReg1   = 4'(s1);
    ID_uses_Src1    = u1;
    IF_ID_SrcReg2   = 4'(s2);
    ID_uses_Src2    = u2;
    ID_is_SW        = sw;
    ID_Branch_taken = br;
  endtask

  // Called just after a falling edge with inputs applied; returns after the next falling edge.
  task automatic step();
    bit df, fi, lu, we;
    #1;
    df = D_miss || (m_fill == 1);
    fi = I_miss || (m_fill == 2);
    lu = ID_EX_MemRead && (ID_EX_reg_rd != 0) &&
         ((IF_ID_SrcReg1 == ID_EX_reg_rd && ID_uses_Src1) ||
          (IF_ID_SrcReg2 == ID_EX_reg_rd && ID_uses_Src2 && !ID_is_SW));
    e_pc = df || lu || fi;
    we = (m_fill != 0) && mem_data_valid;
    check_val("PC_stall",     32'(PC_stall),     32'(e_pc));
    check_val("IF_ID_stall",  32'(IF_ID_stall),  32'(df || lu));
    check_val("IF_ID_flush",  32'(IF_ID_flush),  32'(!df && !lu && (fi || ID_Branch_taken)));
    check_val("ID_EX_stall",  32'(ID_EX_stall),  32'(df));
    check_val("EX_MEM_stall", 32'(EX_MEM_stall), 32'(df));
    check_val("ID_EX_flush",  32'(ID_EX_flush),  32'(!df && lu));
    check_val("MEM_WB_flush", 32'(MEM_WB_flush), 32'(df));
    check_val("mem_req",      32'(mem_req),      32'(m_fill != 0));
    check_val("mem_sel_D",    32'(mem_sel_D),    32'(m_fill == 1));
    check_val("fill_idx",     32'(fill_idx),     32'(m_beats));
    check_val("fill_we",      32'(fill_we),      32'(we));
    check_val("fill_done",    32'(fill_done),    32'(we && m_beats == FW - 1));
    check_val("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    @(posedge clk);
    #1;
    if (rst) begin
      m_fill = 0; m_beats = 0; m_stall = 0;
    end else begin
      if (e_pc && m_stall < 65535) m_stall++;
      if (m_fill == 0) begin
        m_beats = 0;
        if (D_miss) m_fill = 1;
        else if (I_miss) m_fill = 2;
      end else if (mem_data_valid) begin
        if (m_beats == FW - 1) begin
          // Line is in the cache now, so the miss line drops.
          if (m_fill == 1) D_miss = 1'b0;
          else I_miss = 1'b0;
          m_fill = 0;
          m_beats = 0;
        end else begin
          m_beats++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain_misses(input string tag);
    int c = 0;
    mem_data_valid = 1'b1;
    while ((D_miss || I_miss) && c < 300) begin
      step();
      c++;
    end
    check_val(tag, 32'(D_miss || I_miss), 32'd0);
    mem_data_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; I_miss = 1'b0; D_miss = 1'b0; mem_data_valid = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    rst = 1'b0;

    // Load-use interlocks, SW forwarding exemption, branch suppression under load-use.
    set_dec(1, 3, 3, 1, 5, 1, 0, 0); step();
    set_dec(0, 3, 3, 1, 5, 1, 0, 0); step();
    set_dec(1, 0, 0, 1, 0, 1, 0, 0); step();
    set_dec(1, 3, 1, 1, 3, 1, 1, 0); step();
    set_dec(1, 3, 3, 1, 2, 1, 1, 0); step();
    set_dec(1, 3, 3, 1, 0, 0, 0, 1); step();
    check_val("lu_branch_suppressed", 32'(IF_ID_flush), 32'd0);
    set_dec(0, 3, 3, 1, 0, 0, 0, 1); step();
    check_val("branch_after_release", 32'(PC_stall), 32'd0);
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);

    // D fill, one beat every four cycles, from a freshly reset counter.
    rst = 1'b1; step(); rst = 1'b0;
    D_miss = 1'b1;
    for (int c = 0; c <= 32; c++) begin
      mem_data_valid = (c != 0) && (c % 4 == 0);
      step();
    end
    mem_data_valid = 1'b0;
    check_val("d_fill_stall_cycles", 32'(stall_cycles), 32'd33);
    check_val("d_fill_miss_cleared", 32'(D_miss), 32'd0);

    // Simultaneous I and D miss.
    D_miss = 1'b1; I_miss = 1'b1;
    drain_misses("both_fill_timeout");

    // Reset on the fourth beat of a D fill; the miss stays up so the fill restarts.
    D_miss = 1'b1; mem_data_valid = 1'b1;
    repeat (4) step();
    rst = 1'b1; step();
    rst = 1'b0; mem_data_valid = 1'b0; step();
    drain_misses("restart_fill_timeout");

    // Saturation of the stall counter.
    rst = 1'b1; step(); rst = 1'b0;
    D_miss = 1'b1; mem_data_valid = 1'b0;
    repeat (65540) step();
    check_val("stall_saturated", 32'(stall_cycles), 32'hFFFF);

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(299) == 0);
      set_dec($urandom_range(1), $urandom_range(3), $urandom_range(3), $urandom_range(1),
              $urandom_range(3), $urandom_range(1), $urandom_range(1), $urandom_range(3) == 0);
      mem_data_valid = $urandom_range(1);
      if (!D_miss && $urandom_range(15) == 0) D_miss = 1'b1;
      if (!I_miss && $urandom_range(15) == 0) I_miss = 1'b1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
